// File: rtl/ifetch_mem_responder_pkg.sv
// Shared types and constants for the instruction-fetch memory responder and the
// instruction cache that issues its miss requests.
package ifetch_mem_responder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int CNT_W          = 3;

    // An odd fetch address is the cache's "no address" marker, not a real request.
    function automatic logic addr_is_invalid(input logic [31:0] addr);
        return (addr & 32'h1) != 32'h0;
    endfunction

endpackage

// File: rtl/ifetch_mem_responder_req_slot.sv
// Single-entry request holding register. A write overrides a pop in the same
// cycle, so the newest request always survives a slot hand-off.
module ifetch_req_slot (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_i,
    input  logic [31:0] wr_addr_i,
    input  logic        pop_i,
    input  logic        clr_i,
    output logic        valid_o,
    output logic [31:0] addr_o
);

    logic        valid_q;
    logic [31:0] addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end else if (wr_i) begin
            valid_q <= 1'b1;
            addr_q  <= wr_addr_i;
        end else if (pop_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;

endmodule

// File: rtl/ifetch_mem_responder.sv
// Fetches four consecutive bytes from a byte-wide synchronous RAM and returns them
// as a little-endian instruction word, with one queued request and flush support.
module ifetch_mem_responder
    import ifetch_mem_responder_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [31:0]       req_addr,
    input  logic              flush,
    input  logic [7:0]        mem_din,
    output logic [ADDR_W-1:0] mem_a,
    output logic              resp_valid,
    output logic [31:0]       resp_instr,
    output logic [31:0]       resp_addr,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0] LAST_ADV = CNT_W'(BYTES_PER_WORD - 1);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       base_q;
    logic [ADDR_W-1:0] mem_a_q;
    logic              resp_valid_q;
    logic [31:0]       resp_instr_q;
    logic [31:0]       resp_addr_q;

    logic              req_ok;
    logic              done;
    logic              start_en;
    logic [31:0]       start_addr;
    logic              slot_valid;
    logic [31:0]       slot_addr;
    logic              slot_wr;
    logic              slot_pop;

    // A completing read hands over to the slot first; a fresh request only starts
    // directly when nothing is queued, otherwise it lands in (or overwrites) the slot.
    always_comb begin
        req_ok     = req_valid && !addr_is_invalid(req_addr);
        done       = (state_q == READ) && (cnt_q == LAST_CNT);
        slot_pop   = !flush && done && slot_valid;
        start_en   = slot_pop
                   || (req_ok && (flush || (state_q == IDLE) || (done && !slot_valid)));
        start_addr = slot_pop ? slot_addr : req_addr;
        slot_wr    = req_ok && !flush && (state_q == READ) && !(done && !slot_valid);
    end

    ifetch_req_slot u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_i      (slot_wr),
        .wr_addr_i (req_addr),
        .pop_i     (slot_pop),
        .clr_i     (flush),
        .valid_o   (slot_valid),
        .addr_o    (slot_addr)
    );

    // Byte k arrives two edges after mem_a was set to base+k; the top byte is taken
    // straight from mem_din on the completing edge.
    for (genvar gi = 0; gi < BYTES_PER_WORD - 1; gi++) begin : g_byte
        logic [7:0] b_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                b_q <= '0;
            end else if ((state_q == READ) && !flush && (cnt_q == CNT_W'(gi + 1))) begin
                b_q <= mem_din;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            base_q       <= '0;
            mem_a_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_instr_q <= '0;
            resp_addr_q  <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            if (done && !flush) begin
                resp_valid_q <= 1'b1;
                resp_instr_q <= {mem_din, g_byte[2].b_q, g_byte[1].b_q, g_byte[0].b_q};
                resp_addr_q  <= base_q;
            end
            if (start_en) begin
                state_q <= READ;
                base_q  <= start_addr;
                mem_a_q <= start_addr[ADDR_W-1:0];
                cnt_q   <= '0;
            end else if (flush || done) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else if (state_q == READ) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (cnt_q < LAST_ADV) begin
                    mem_a_q <= base_q[ADDR_W-1:0] + ADDR_W'(cnt_q) + ADDR_W'(1);
                end
            end
        end
    end

    assign mem_a      = mem_a_q;
    assign resp_valid = resp_valid_q;
    assign resp_instr = resp_instr_q;
    assign resp_addr  = resp_addr_q;
    assign busy       = (state_q != IDLE) || slot_valid;

endmodule

// File: doc/ifetch_mem_responder.md
# ifetch_mem_responder

Memory-side responder for the instruction cache's miss-request interface. Accepts one-cycle fetch requests (address and asking pulse), reads four consecutive bytes from the byte-wide main RAM, and assembles them into a little-endian 32-bit word. Returns the word with a one-cycle ready pulse. Sits between the instruction cache and the RAM port, with a single-entry request slot and a flush input for pipeline redirects.

## Interface
- ADDR_W, default 17: RAM byte-address width; higher request bits are ignored.
- clk  input  1  sole clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  1  one-cycle fetch request pulse from the instruction cache.
- req_addr  input  32  fetch byte address; valid when req_valid=1.
- flush  input  1  abandons the in-flight read and the pending request.
- mem_din  input  8  RAM read data; byte for the address presented one cycle earlier.
- mem_a  output  ADDR_W  RAM byte address, registered.
- resp_valid  output  1  one-cycle pulse; instruction word valid.
- resp_instr  output  32  assembled word {b3,b2,b1,b0}.
- resp_addr  output  32  request address that produced resp_instr.
- busy  output  1  high while state is not IDLE or the slot is full.

## Operation
- Reset values: mem_a=0, resp_valid=0, resp_instr=0, resp_addr=0, busy=0, state=IDLE, slot empty, byte counter=0.
- Request filter: if req_addr[0]=1, the request is dropped. No response, no state change. This is the cache's "no address" encoding.
- States:
  - IDLE: a valid request moves to READ. Sets base=req_addr, mem_a=req_addr[ADDR_W-1:0], cnt=0.
  - READ: cnt counts 0..4 across edges.
    - mem_a advances to base+cnt+1 while cnt<3.
    - mem_din is captured into byte register cnt-1 when cnt≥1.
  - At cnt=4 the edge drives resp_instr={mem_din,b2,b1,b0}, resp_addr=base, resp_valid=1.
    - If the slot is full: starts the slot request immediately (stays in READ, cnt=0) and empties the slot.
    - Otherwise: returns to IDLE.
- Request arriving in READ: written into the slot. If the slot is already full, the new request overwrites it; the latest address wins, matching cache miss semantics.
- Request on the same edge the read completes, with the slot empty: started directly as the next read.
- Address arithmetic: base+k is computed modulo 2^ADDR_W, so mem_a wraps from all-ones to 0.
- flush=1: state→IDLE, slot emptied, cnt=0. resp_valid is forced 0 on that edge, even if the read would have completed.
- flush and req_valid on the same edge: the flush applies first, then the request is accepted as from IDLE.
- rst_n low at any point: all state returns to reset values immediately, mid-read included. No response is produced for the interrupted request.

## Timing
- Request sampled at edge E0. mem_a = base, base+1, base+2, base+3 after E0..E3. Bytes are captured at E2..E5. resp_valid is high in the cycle after E5.
- Latency is 5 edges. Sustained throughput with the slot occupied is one word per 5 cycles.
- resp_valid is never high for two consecutive cycles.
- resp_instr and resp_addr hold their values until the next response.
- mem_a holds its last value in IDLE.

## Structure
- Shared package:
  - state enum {IDLE, READ}.
  - BYTES_PER_WORD=4.
  - The 3-bit counter width.
  - The odd-address "invalid" rule, as a function, shared with the instruction cache.
- One sub-module: ifetch_req_slot. Single-entry request register with valid bit, write (overwrite), pop and clear ports.
- The byte assembler stays inline in the top FSM.

## Test plan
- Single fetch: req 0x00001000; RAM bytes 0x13,0x05,0x00,0x00 at 0x1000..0x1003.
  - mem_a = 0x1000..0x1003 on consecutive cycles.
  - resp_valid one cycle after E5, with resp_instr=0x00000513 and resp_addr=0x00001000.
- Back-to-back: req 0x2000, then req 0x2004 two cycles later.
  - Two responses, exactly 5 cycles apart, in order.
  - Third req 0x3000 before the second starts overwrites the slot, so the responses are 0x2000 then 0x3000.
- Flush mid-read: flush at cycle E3 of req 0x4000.
  - No resp_valid; busy=0 after the flush edge.
  - Flush coincident with req 0x5000 yields a single response for 0x5000.
- Odd address: req 0x00001001 yields no mem_a change, no response, and busy stays 0.
- Wrap: ADDR_W=17, req 0x0001FFFE.
  - mem_a = 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
  - resp_addr=0x0001FFFE.
- Reset mid-read: assert rst_n=0 between edges at E2.
  - All outputs are 0 before the next edge.
  - After release, req 0x6000 completes with normal 5-edge latency.
